// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scanner.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}. Anodes are active-low.
package seg_pkg;

  typedef logic [1:0] dig_t;

  // Digit slots, right to left on the board.
  localparam dig_t DIG_FLAG = 2'd0;
  localparam dig_t DIG_SUM  = 2'd1;
  localparam dig_t DIG_B    = 2'd2;
  localparam dig_t DIG_A    = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam logic [6:0] GLYPH_DARK  = 7'h7F;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;

  localparam logic [6:0] GLYPH_HEX_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_HEX_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_HEX_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_HEX_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_HEX_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_HEX_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_HEX_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_HEX_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_HEX_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_HEX_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_HEX_A = 7'b0001000;
  localparam logic [6:0] GLYPH_HEX_B = 7'b0000011;
  localparam logic [6:0] GLYPH_HEX_C = 7'b1000110;
  localparam logic [6:0] GLYPH_HEX_D = 7'b0100001;
  localparam logic [6:0] GLYPH_HEX_E = 7'b0000110;
  localparam logic [6:0] GLYPH_HEX_F = 7'b0001110;

  // One frame's worth of adder state, frozen at the frame wrap.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       of_s;
    logic       c_msb;
  } snap_t;

endpackage

// File: rtl/hex_glyph.sv
// hex_glyph: combinational 4-bit value to active-low seven-segment pattern.
//   nibble : value to display
//   seg    : active-low segments {g,f,e,d,c,b,a}
module hex_glyph
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_DARK;
    case (nibble)
      4'h0: seg = GLYPH_HEX_0;
      4'h1: seg = GLYPH_HEX_1;
      4'h2: seg = GLYPH_HEX_2;
      4'h3: seg = GLYPH_HEX_3;
      4'h4: seg = GLYPH_HEX_4;
      4'h5: seg = GLYPH_HEX_5;
      4'h6: seg = GLYPH_HEX_6;
      4'h7: seg = GLYPH_HEX_7;
      4'h8: seg = GLYPH_HEX_8;
      4'h9: seg = GLYPH_HEX_9;
      4'hA: seg = GLYPH_HEX_A;
      4'hB: seg = GLYPH_HEX_B;
      4'hC: seg = GLYPH_HEX_C;
      4'hD: seg = GLYPH_HEX_D;
      4'hE: seg = GLYPH_HEX_E;
      4'hF: seg = GLYPH_HEX_F;
      default: seg = GLYPH_DARK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit time-multiplexed seven-segment scanner for the
// 4-bit adder. Digits left to right: A, B, SUM, flag glyph ('F' blinking on
// signed overflow, else 'C' on carry, else dark). Inputs are sampled once per
// frame so a frame never mixes old and new values.
//   clk, rst_n          : clock, async active-low reset
//   A, B, SUM           : adder operands and result
//   OF_S, C_MSB         : signed overflow and carry-out flags
//   SEGMENTS            : active-low cathodes, [0]=a .. [6]=g, registered
//   AN                  : active-low anodes, [0]=rightmost, registered
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_W   = 17,
  parameter int BLANK   = 64,
  parameter int BLINK_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] SUM,
  input  logic       OF_S,
  input  logic       C_MSB,
  output logic [6:0] SEGMENTS,
  output logic [3:0] AN
);

  localparam logic [DIV_W-1:0] BLANK_CNT = DIV_W'(BLANK);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  dig_t               dig_q, dig_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  snap_t              snap_q, snap_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic       div_tc;
  logic       frame_wrap;
  logic       blanking;
  logic [3:0] nibble;
  logic [6:0] hex_seg;
  logic [6:0] flag_seg;
  logic       flag_lit;
  logic [6:0] digit_seg;
  logic       digit_lit;

  // Single shared decoder after the nibble mux; digit 0 bypasses it.
  hex_glyph u_hex_glyph (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    div_tc     = &div_cnt_q;
    frame_wrap = div_tc && (dig_q == DIG_A);
    blanking   = div_cnt_q < BLANK_CNT;

    div_cnt_d = div_cnt_q + DIV_W'(1);
    dig_d     = div_tc ? dig_q + 2'd1 : dig_q;
    blink_d   = blink_q + BLINK_W'(1);

    snap_d = snap_q;
    if (frame_wrap) begin
      snap_d.a     = A;
      snap_d.b     = B;
      snap_d.sum   = SUM;
      snap_d.of_s  = OF_S;
      snap_d.c_msb = C_MSB;
    end

    case (dig_q)
      DIG_A:   nibble = snap_q.a;
      DIG_B:   nibble = snap_q.b;
      default: nibble = snap_q.sum;
    endcase

    // Overflow wins over carry; during the off half of the blink the digit
    // is dark rather than falling back to 'C'.
    flag_seg = GLYPH_DARK;
    flag_lit = 1'b0;
    if (snap_q.of_s) begin
      if (!blink_q[BLINK_W-1]) begin
        flag_seg = GLYPH_F;
        flag_lit = 1'b1;
      end
    end else if (snap_q.c_msb) begin
      flag_seg = GLYPH_C;
      flag_lit = 1'b1;
    end

    if (dig_q == DIG_FLAG) begin
      digit_seg = flag_seg;
      digit_lit = flag_lit;
    end else begin
      digit_seg = hex_seg;
      digit_lit = 1'b1;
    end

    an_d  = AN_OFF;
    seg_d = GLYPH_DARK;
    if (!blanking && digit_lit) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      dig_q     <= DIG_FLAG;
      blink_q   <= '0;
      snap_q    <= '0;
      an_q      <= AN_OFF;
      seg_q     <= GLYPH_DARK;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      blink_q   <= blink_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN       = an_q;
  assign SEGMENTS = seg_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed four-digit seven-segment scanner that sits directly downstream of the 4-bit adder. It consumes operands A and B, the result SUM, and the flags OF_S and C_MSB, and drives the board's shared-cathode bus and four anodes. Inputs are snapshotted once per scan frame so digits never tear. Digit 0 shows a flag glyph, and blinks on signed overflow.

## Interface
- DIV_W, default 17: each digit slot lasts 2**DIV_W clocks.
- BLANK, default 64: number of clocks at the start of every slot with all anodes off (anti-ghosting). Must satisfy 0 < BLANK < 2**DIV_W.
- BLINK_W, default 26: width of the blink counter. Its MSB is the blink phase.
- clk  in  1: system clock.
- rst_n  in  1: reset, asynchronous and active-low.
- A  in  4: operand A.
- B  in  4: operand B.
- SUM  in  4: adder result.
- OF_S  in  1: signed overflow flag.
- C_MSB  in  1: carry out of bit 3.
- SEGMENTS  out  7: active-low cathodes. SEGMENTS[0]=a … SEGMENTS[6]=g. Registered.
- AN  out  4: active-low anodes. AN[0] is the rightmost digit. Registered.

## Operation
- Prescaler `div_cnt` (DIV_W bits) counts up every clock and wraps freely. Terminal count is all-ones.
- Digit index `dig` (2 bits) advances 0→1→2→3→0 on the prescaler terminal count.
- Snapshot registers {A,B,SUM,OF_S,C_MSB} load from the inputs on the cycle where `dig`=3 and the prescaler is at terminal count, i.e. at the frame wrap.
- Digit mapping:
  - digit 3 = hex(A snapshot)
  - digit 2 = hex(B snapshot)
  - digit 1 = hex(SUM snapshot)
  - digit 0 = flag glyph
- Flag glyph on digit 0, overflow has priority:
  - OF_S=1 shows 'F' (SEGMENTS=7'b0001110) when the blink phase is 0, and the digit is dark when the phase is 1.
  - Else C_MSB=1 shows 'C' (7'b1000110).
  - Else the digit is dark.
- A dark digit has its anode high and SEGMENTS=7'h7F.
- Blanking: while `div_cnt` < BLANK, AN=4'b1111 and SEGMENTS=7'h7F.
- Otherwise AN has exactly one zero, at bit `dig`, unless that digit is dark.
- Blink counter (BLINK_W bits) free-runs continuously and is independent of the scan.
- Hex glyphs use the standard pattern, for example:
  - 0 = 7'b1000000
  - 8 = 7'b0000000
  - A = 7'b0001000
  - F = 7'b0001110

## Timing
- Reset (asynchronous assert, immediate):
  - AN=4'b1111, SEGMENTS=7'h7F.
  - div_cnt=0, dig=0, blink counter=0.
  - All snapshot registers = 0.
- Reset release is synchronous to clk. Counting starts on the first edge with rst_n high.
- The first frame after reset shows snapshot zeros: "0 0 0 dark". Live inputs appear from the frame after the first wrap.
- Output latency is one clock. AN and SEGMENTS reflect the `div_cnt`/`dig`/snapshot values of the previous cycle.
- Input changes outside the wrap cycle are invisible until the next wrap. Changes on the wrap cycle itself are captured.
- Reset asserted mid-frame forces the outputs dark in the same cycle, without waiting for a clock edge.
- A frame is 4·2**DIV_W clocks. With defaults at 100 MHz, the refresh is about 190 Hz per frame, and the blink period is about 0.67 s.
- Simultaneous OF_S and C_MSB: 'F' blinking is shown and 'C' is never shown.

## Structure
- Package `seg_pkg`:
  - glyph constants: hex 0–F, GLYPH_C, GLYPH_F, GLYPH_DARK=7'h7F
  - 2-bit digit-index type
  - AN_OFF=4'b1111
- Sub-module `hex_glyph`: purely combinational 4-bit to active-low 7-segment lookup.
  - Instantiated once, after the digit mux, on the selected nibble.
  - Digit 0 bypasses it with the flag-glyph mux.
- Top level contains the prescaler, digit index, snapshot registers, blink counter, blanking compare and output registers.

## Test plan
Run with DIV_W=2, BLANK=1, BLINK_W=3.
- Hold rst_n=0 for 5 clocks with random inputs. Required: AN=4'b1111 and SEGMENTS=7'h7F throughout. Deassert mid-clock and assert again: outputs go dark with no clock edge.
- Drive A=4'hA, B=4'h8, SUM=4'h2, flags 0, and run 2 frames. Second frame:
  - AN=4'b0111 with SEGMENTS=7'b0001000
  - AN=4'b1011 with 7'b0000000
  - AN=4'b1101 with 7'b0100100
  - digit 0 dark
  - each slot preceded by one all-off clock
- Set C_MSB=1, OF_S=0. In the next frame, digit 0 shows AN=4'b1110 with SEGMENTS=7'b1000110 in every slot.
- Set OF_S=1 and C_MSB=1. Digit 0 alternates 'F' (7'b0001110) and dark according to blink MSB. 'C' never appears.
- Change SUM from 4'h2 to 4'h7 during the digit-1 slot. Required: digit 1 still shows '2' for the rest of that frame, and '7' (7'b1111000) from the next frame on.
- Assert rst_n low during the digit-2 slot. Required: immediate dark outputs. After release, digit index restarts at 0 and snapshots read zero for the first frame.
